imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit words stored (power of two, 2..1024).
REQ-002 Parameter: LATENCY, 2, wait cycles between request accept and response valid (0..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clock  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: req_valid  input  1  fetch request from core.
REQ-007 Port: req_addr  input  32  word address (PC units, not bytes).
REQ-008 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-009 Port: resp_valid  output  1  resp_data/resp_error valid.
REQ-010 Port: resp_ready  input  1  core accepts response this cycle.
REQ-011 Port: resp_data  output  32  instruction word.
REQ-012 Port: resp_error  output  1  request address was >= DEPTH.
REQ-013 Port: load_en  input  1  program-load write strobe.
REQ-014 Port: load_addr  input  32  word address for load write.
REQ-015 Port: load_data  input  32  word to write.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; one request outstanding at most.
REQ-017 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready on a rising edge.
REQ-018 On handshake, req_addr SHALL be latched; next state WAIT with counter = LATENCY, or RESP directly if LATENCY = 0.
REQ-019 In WAIT the counter SHALL decrement each cycle; at counter = 1 the memory is read and state moves to RESP next cycle.
REQ-020 Accept-to-resp_valid latency SHALL be exactly LATENCY+1 cycles.
REQ-021 Entering RESP: resp_data = mem[latched_addr] and resp_error = 0 if latched_addr < DEPTH; otherwise resp_data = 0, resp_error = 1.
REQ-022 In RESP, resp_valid = 1 and resp_data/resp_error SHALL stay stable until resp_valid & resp_ready, then return to IDLE.
REQ-023 Back-to-back: a new request SHALL NOT be accepted in the same cycle a response completes; earliest next accept is the following cycle.
REQ-024 Outside RESP, resp_valid = 0 and resp_data/resp_error hold their last values.
REQ-025 load_en SHALL write load_data to mem[load_addr] on the rising edge in any FSM state; writes with load_addr >= DEPTH are ignored.
REQ-026 A load and memory read to the same address in the same cycle SHALL return old data (read-before-write).
REQ-027 A load to the latched address after the read cycle SHALL NOT alter a pending resp_data.
REQ-028 Only the low log2(DEPTH) address bits index memory; range check uses all 32 bits.

Reset
REQ-029 On reset: state = IDLE, counter = 0, req_ready = 0 in the reset cycle and 1 the cycle after, resp_valid = 0, resp_data = 0, resp_error = 0.
REQ-030 Reset mid-transaction SHALL discard the outstanding request without producing a response.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-032 Load mem[0..3] = 0x20080005, 0x20090003, 0x01095020, 0x08000000; request addr 2 with LATENCY = 2, resp_ready = 1 -> resp_valid exactly 3 cycles after accept, resp_data = 0x01095020, resp_error = 0.
REQ-033 Request addr 0x00000100 with DEPTH = 256 -> resp_valid, resp_error = 1, resp_data = 0.
REQ-034 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and resp_data stable, req_ready = 0 throughout; accept on cycle 6, req_ready = 1 the next cycle.
REQ-035 Assert reset during WAIT -> next cycle state IDLE, resp_valid never asserts for that request, mem[0..3] unchanged on re-read.
REQ-036 load_en to addr 1 with 0xDEADBEEF in the read cycle of a request for addr 1 -> resp_data = 0x20090003; repeat request -> 0xDEADBEEF.
REQ-037 LATENCY = 0, continuous req_valid and resp_ready with addrs 0,1,2,3 -> one response every 2 cycles, data in order.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder for a simple core fetch port. It accepts one
//   word-addressed fetch at a time, waits LATENCY cycles and then presents the
//   instruction word (or an out-of-range error) until the core takes it. A
//   separate program-load port writes words into the memory in any state.
//
//   Ports
//     clock       rising-edge clock for all state
//     reset       synchronous active-high reset
//     req_valid   fetch request from core
//     req_addr    fetch word address (32 bits, PC units)
//     req_ready   a request can be accepted this cycle
//     resp_valid  resp_data/resp_error are valid
//     resp_ready  core accepts the response this cycle
//     resp_data   instruction word
//     resp_error  fetched address was >= DEPTH
//     load_en     program-load write strobe
//     load_addr   program-load word address
//     load_data   program-load word
//
//   state | meaning
//   IDLE  | ready for a request (req_ready = 1 except in the cycle after reset)
//   WAIT  | request latched, counting down the access latency
//   RESP  | response presented, holding until resp_ready

module imem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_error,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] rd_addr;
    logic [31:0] rd_word;
    logic        rd_err;
    logic [31:0] mem [DEPTH];

    // In IDLE the read path looks at the incoming address so that a zero
    // latency fetch can be answered on the accept edge itself; otherwise it
    // uses the address latched at accept.
    always_comb begin
        rd_addr = (state == IDLE) ? req_addr : addr_q;
        rd_err  = (rd_addr >= 32'(DEPTH));
        rd_word = rd_err ? 32'd0 : mem[rd_addr[AW-1:0]];
    end

    // Non-blocking write alongside the registered read gives read-before-write
    // when both hit the same word on one edge.
    always_ff @(posedge clock) begin
        if (load_en && (load_addr < 32'(DEPTH))) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            resp_data  <= rd_word;
                            resp_error <= rd_err;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            cnt   <= 4'(LATENCY);
                            state <= WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        resp_data  <= rd_word;
                        resp_error <= rd_err;
                        resp_valid <= 1'b1;
                        cnt        <= 4'd0;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // req_ready rises only after the completing edge, so no
                    // new request can be taken in the completion cycle.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a main instance with LATENCY = 2 checked every
// cycle against a transaction-level model, plus a LATENCY = 0 instance used
// for the back-to-back throughput case.

module tb_imem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_error;
    logic [31:0] req_addr = '0, resp_data;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0, load_data = '0;

    logic        z_req_valid = 1'b0, z_req_ready, z_resp_valid, z_resp_ready = 1'b0, z_resp_error;
    logic [31:0] z_req_addr = '0, z_resp_data;
    logic        z_load_en = 1'b0;
    logic [31:0] z_load_addr = '0, z_load_data = '0;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_z (
        .clock(clock), .reset(reset),
        .req_valid(z_req_valid), .req_addr(z_req_addr), .req_ready(z_req_ready),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_data(z_resp_data), .resp_error(z_resp_error),
        .load_en(z_load_en), .load_addr(z_load_addr), .load_data(z_load_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [31:0] prog [4] = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'h0800_0000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Transaction-level model: a fetch accepted on an edge is answered with the
    // memory contents seen LAT edges later (before that edge's load), and the
    // response is visible one cycle after that read edge.
    logic [31:0] model_mem [DEPTH];
    bit          m_ready, m_valid, m_err, m_pend;
    logic [31:0] m_data, m_addr;
    int          m_age;

    always @(posedge clock) begin
        if (reset) begin
            m_ready = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_pend = 1'b0;
            m_data  = '0;   m_age   = 0;
        end else if (m_valid) begin
            if (resp_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_pend) begin
            m_age++;
            if (m_age == LAT) begin
                m_err   = (m_addr >= DEPTH);
                m_data  = m_err ? 32'd0 : model_mem[int'(m_addr)];
                m_valid = 1'b1;
                m_pend  = 1'b0;
            end
        end else if (!m_ready) begin
            m_ready = 1'b1;
        end else if (req_valid) begin
            m_ready = 1'b0;
            m_pend  = 1'b1;
            m_age   = 0;
            m_addr  = req_addr;
        end
        if (load_en && load_addr < DEPTH) model_mem[int'(load_addr)] = load_data;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("req_ready",  32'(req_ready),  32'(m_ready));
            chk("resp_valid", 32'(resp_valid), 32'(m_valid));
            chk("resp_data",  resp_data,       m_data);
            chk("resp_error", 32'(resp_error), 32'(m_err));
        end
    end

    function automatic logic [31:0] pick();
        int r = $urandom_range(0, 9);
        if (r == 0) return 32'h100 + 32'($urandom_range(0, 7));
        if (r == 1) return {1'b1, 31'($urandom_range(0, 255))};
        if (r < 5)  return 32'($urandom_range(0, 7));
        return 32'($urandom_range(0, 255));
    endfunction

    task automatic do_req(input logic [31:0] a, output int lat);
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, idx, cyc, nresp, last;
        bit acc, saw;

        step();
        step();
        chk_en = 1'b1;
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data",  resp_data,       32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        reset = 1'b0;
        step();
        chk("req_ready_after_rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i);
            load_data = (i < 4) ? prog[i] : $urandom;
            z_load_en   = (i < 4);
            z_load_addr = 32'(i);
            z_load_data = (i < 4) ? prog[i] : 32'd0;
            step();
        end
        load_en   = 1'b0;
        z_load_en = 1'b0;

        resp_ready = 1'b1;
        do_req(32'd2, lat);
        chk("lat_addr2",  32'(lat),        32'd3);
        chk("data_addr2", resp_data,       32'h0109_5020);
        chk("err_addr2",  32'(resp_error), 32'd0);
        step();

        do_req(32'h100, lat);
        chk("valid_oor",  32'(resp_valid), 32'd1);
        chk("err_oor",    32'(resp_error), 32'd1);
        chk("data_oor",   resp_data,       32'd0);
        step();

        do_req(32'h8000_0002, lat);
        chk("err_hibit",  32'(resp_error), 32'd1);
        step();

        resp_ready = 1'b0;
        do_req(32'd3, lat);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_data",  resp_data,       32'h0800_0000);
            chk("stall_ready", 32'(req_ready),  32'd0);
            step();
        end
        resp_ready = 1'b1;
        step();
        chk("post_stall_ready", 32'(req_ready),  32'd1);
        chk("post_stall_valid", 32'(resp_valid), 32'd0);
        chk("post_stall_hold",  resp_data,       32'h0800_0000);

        req_valid = 1'b1;
        req_addr  = 32'd0;
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            saw |= resp_valid;
            step();
        end
        chk("mid_rst_no_resp", 32'(saw), 32'd0);
        for (int i = 0; i < 4; i++) begin
            do_req(32'(i), lat);
            chk("reread", resp_data, prog[i]);
            step();
        end

        while (!req_ready) step();
        req_valid = 1'b1;
        req_addr  = 32'd1;
        step();
        req_valid = 1'b0;
        step();
        load_en   = 1'b1;
        load_addr = 32'd1;
        load_data = 32'hDEAD_BEEF;
        step();
        load_en = 1'b0;
        chk("rbw_valid", 32'(resp_valid), 32'd1);
        chk("rbw_old",   resp_data,       32'h2009_0003);
        step();
        do_req(32'd1, lat);
        chk("rbw_new", resp_data, 32'hDEAD_BEEF);
        step();

        z_resp_ready = 1'b1;
        z_req_valid  = 1'b1;
        idx = 0; cyc = 0; nresp = 0; last = -1;
        while (nresp < 4 && cyc < 40) begin
            z_req_addr = 32'(idx % 4);
            acc = z_req_ready;
            step();
            cyc++;
            if (acc) idx++;
            if (z_resp_valid) begin
                chk("z_data", z_resp_data, prog[nresp]);
                chk("z_err",  32'(z_resp_error), 32'd0);
                if (last >= 0) chk("z_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                nresp++;
            end
        end
        z_req_valid = 1'b0;
        chk("z_count", 32'(nresp), 32'd4);

        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_addr   = pick();
            resp_ready = ($urandom_range(0, 3) != 0);
            load_en    = ($urandom_range(0, 5) == 0);
            load_addr  = pick();
            load_data  = $urandom;
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        load_en   = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
